// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared constants, the queue entry type and the
// J-immediate decoder used by the fetch stage and its instruction queue.
package instr_fetch_pkg;

   localparam int          INSTR_W          = 32;
   localparam logic [6:0]  OPC_JAL          = 7'b1101111;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // One instruction-queue slot: the fetched word, the PC it came from and
   // whether the fetch stage redirected on it.
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [31:0]        pc;
      logic               pred;
   } iq_entry_t;

   // Sign-extended JAL offset; bit 0 is always zero.
   function automatic logic [31:0] j_imm(input logic [INSTR_W-1:0] instr);
      return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: cache lookup port plus decoder-facing queue head.
//   master (instr_fetch): drives fetch_signal/fetch_addr and the iq_* head,
//                         samples fetch_done/fetch_instr and iq_ready.
//   slave  (cache + decoder side): the mirror image.
interface instr_fetch_if;
   import instr_fetch_pkg::*;

   logic               fetch_signal;
   logic [31:0]        fetch_addr;
   logic               fetch_done;
   logic [INSTR_W-1:0] fetch_instr;

   logic               iq_valid;
   logic [INSTR_W-1:0] iq_instr;
   logic [31:0]        iq_pc;
   logic               iq_pred_jump;
   logic               iq_ready;

   modport master (
      output fetch_signal, fetch_addr, iq_valid, iq_instr, iq_pc, iq_pred_jump,
      input  fetch_done, fetch_instr, iq_ready
   );

   modport slave (
      input  fetch_signal, fetch_addr, iq_valid, iq_instr, iq_pc, iq_pred_jump,
      output fetch_done, fetch_instr, iq_ready
   );

endinterface

// File: rtl/instr_fetch_queue.sv
// instr_queue: circular FIFO of fetched instructions.
//   clk, rst_n     : clock, async active-low reset (pointers/count only)
//   en             : global enable; nothing moves while low
//   flush          : empties the queue, overriding push/pop
//   push/push_entry: write at tail (caller guarantees not full)
//   pop            : advance head (caller guarantees not empty)
//   head_entry     : entry at head, meaningless when count == 0
//   count          : occupancy, 0..2**IQ_WIDTH
module instr_queue
   import instr_fetch_pkg::*;
#(
   parameter int IQ_WIDTH = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              flush,
   input  logic              push,
   input  iq_entry_t         push_entry,
   input  logic              pop,
   output iq_entry_t         head_entry,
   output logic [IQ_WIDTH:0] count
);

   localparam int IQ_SIZE = 2**IQ_WIDTH;

   iq_entry_t           mem [IQ_SIZE];
   logic [IQ_WIDTH-1:0] head, tail;

   // Pointers are exactly IQ_WIDTH bits wide, so increments wrap for free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (en) begin
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: ;
            endcase
         end
      end
   end

   // Storage carries no reset; contents are only observed through count.
   always_ff @(posedge clk) begin
      if (en && push && !flush) mem[tail] <= push_entry;
   end

   assign head_entry = mem[head];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC register, cache lookup handshake and instruction queue.
//   clk_in, rst_in : clock, async active-low reset
//   rdy_in         : global stall, all state holds while low
//   clear_signal   : flush queue and redirect PC to clear_pc
//   bus            : instr_fetch_if.master (cache lookup + queue head)
// Build option: define JAL_PREDICT_EN to redirect on JAL and mark the entry
// as predicted; otherwise next PC is always PC+4 and iq_pred_jump stays 0.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int          IQ_WIDTH = 3,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          rdy_in,
   input  logic          clear_signal,
   input  logic [31:0]   clear_pc,
   instr_fetch_if.master bus
);

   localparam int                IQ_SIZE = 2**IQ_WIDTH;
   localparam logic [IQ_WIDTH:0] IQ_FULL = (IQ_WIDTH+1)'(IQ_SIZE);

   logic [31:0]       pc, next_pc;
   logic [IQ_WIDTH:0] count;
   logic              push, pop, pred;
   iq_entry_t         push_entry, head_entry;

   // Fetch is gated by full, not by "full and no pop": a pop into a full
   // queue frees a slot that is only refilled on the following cycle.
   assign bus.fetch_signal = rst_in & ~clear_signal & (count != IQ_FULL);
   assign bus.fetch_addr   = pc;
   assign bus.iq_valid     = (count != '0);

   assign push = bus.fetch_signal & bus.fetch_done;
   assign pop  = bus.iq_valid & bus.iq_ready;

`ifdef JAL_PREDICT_EN
   assign pred    = (bus.fetch_instr[6:0] == OPC_JAL);
   assign next_pc = pred ? pc + j_imm(bus.fetch_instr) : pc + 32'd4;
`else
   assign pred    = 1'b0;
   assign next_pc = pc + 32'd4;
`endif

   // A miss simply leaves push low, so pc holds until the hit arrives.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)           pc <= RESET_PC;
      else if (rdy_in) begin
         if (clear_signal)   pc <= clear_pc;
         else if (push)      pc <= next_pc;
      end
   end

   assign push_entry = '{instr: bus.fetch_instr, pc: pc, pred: pred};

   instr_queue #(.IQ_WIDTH(IQ_WIDTH)) u_iq (
      .clk        (clk_in),
      .rst_n      (rst_in),
      .en         (rdy_in),
      .flush      (clear_signal),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head_entry (head_entry),
      .count      (count)
   );

   assign bus.iq_instr     = head_entry.instr;
   assign bus.iq_pc        = head_entry.pc;
   assign bus.iq_pred_jump = head_entry.pred;

endmodule
